// File: rtl/dmem_pkg.sv
// dmem_pkg: shared states, op encoding and sizing helpers for the data-memory responder.
package dmem_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    typedef enum logic [1:0] {OP_NOP, OP_LOAD, OP_STORE} op_e;
    localparam int CNT_W = 4;
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bus between the datapath and the data-memory responder.
interface dmem_responder_if #(parameter int DATA_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              mem_read;
    logic              mem_to_write;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rdata;
    logic              rsp_err;
    modport master (output req_valid, mem_read, mem_to_write, addr, wdata,
                    input req_ready, rsp_valid, rdata, rsp_err);
    modport slave (input req_valid, mem_read, mem_to_write, addr, wdata,
                   output req_ready, rsp_valid, rdata, rsp_err);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: word storage with synchronous write and combinational read on a shared index.
module dmem_array import dmem_pkg::*; #(
    parameter int DEPTH_WORDS = 256,
    parameter int DATA_W      = 32
) (
    input  logic                          clk_i,
    input  logic                          we_i,
    input  logic [idx_w(DEPTH_WORDS)-1:0] idx_i,
    input  logic [DATA_W-1:0]             wdata_i,
    output logic [DATA_W-1:0]             rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    always_ff @(posedge clk_i)
        if (we_i) mem_q[idx_i] <= wdata_i;
    assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store responder with fixed wait-state latency, one request in flight.
// Define DMEM_ALIGN_CHECK_EN to flag and suppress misaligned loads/stores.
module dmem_responder import dmem_pkg::*; #(
    parameter int DEPTH_WORDS = 256,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input logic             clk_i,
    input logic             rst_ni,
    dmem_responder_if.slave bus
);
    localparam int IW = idx_w(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
    logic [1:0]        rst_sync_q;
    logic              rst_n;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_e               op_q, in_op, src_op;
    logic [IW+1:0]     addr_q, src_addr;
    logic [DATA_W-1:0] wdata_q, src_wdata, rdata_q, rd_word;
    logic              err_q, accept, direct, enter_resp, mis, we;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) rst_sync_q <= '0;
        else rst_sync_q <= {rst_sync_q[0], 1'b1};
    assign rst_n = rst_sync_q[1];
    assign in_op = bus.mem_to_write ? OP_STORE : bus.mem_read ? OP_LOAD : OP_NOP;
    assign bus.req_ready = state_q != ST_WAIT;
    assign bus.rsp_valid = state_q == ST_RESP;
    assign bus.rdata = rdata_q;
    assign bus.rsp_err = err_q;
    assign accept = bus.req_valid && bus.req_ready;
    // With zero wait states the request is served on its own accept edge, so use it directly.
    assign direct = WAIT_CYCLES == 0 && accept;
    assign src_op = direct ? in_op : op_q;
    assign src_addr = direct ? bus.addr[IW+1:0] : addr_q;
    assign src_wdata = direct ? bus.wdata : wdata_q;
    always_comb begin
        state_d = accept ? (WAIT_CYCLES == 0 ? ST_RESP : ST_WAIT)
                : state_q == ST_WAIT ? (cnt_q == '0 ? ST_RESP : ST_WAIT) : ST_IDLE;
        cnt_d = accept ? CNT_LOAD : state_q == ST_WAIT && cnt_q != '0 ? cnt_q - CNT_W'(1) : cnt_q;
    end
    assign enter_resp = state_d == ST_RESP;
`ifdef DMEM_ALIGN_CHECK_EN
    assign mis = src_op != OP_NOP && src_addr[1:0] != 2'b00;
`else
    assign mis = &{1'b0, src_addr[1:0]};
`endif
    assign we = enter_resp && src_op == OP_STORE && !mis;
    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .DATA_W(DATA_W)) u_array (
        .clk_i   (clk_i),
        .we_i    (we),
        .idx_i   (src_addr[IW+1:2]),
        .wdata_i (src_wdata),
        .rdata_o (rd_word)
    );
    always_ff @(posedge clk_i or negedge rst_n)
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q    <= in_op;
                addr_q  <= bus.addr[IW+1:0];
                wdata_q <= bus.wdata;
            end
            if (enter_resp) begin
                err_q <= mis;
                if (mis) rdata_q <= '0;
                else if (src_op == OP_LOAD) rdata_q <= rd_word;
            end
        end
endmodule
